// File: rtl/r2r_pkg.sv
// Shared definitions for the R2R ladder path: SAR state encoding, comparator polarity
// and the ladder width default used by both the DAC output and ADC input blocks.
package r2r_pkg;

   localparam int R2R_DATA_WIDTH = 8;

   // Comparator output level meaning "analog input >= DAC output": keep the trial bit.
   localparam logic COMP_KEEP = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } sar_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for bringing asynchronous levels into the clk domain.
// Synchronous active-low reset clears both stages.
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] q_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         meta_reg <= '0;
         q_reg    <= '0;
      end else begin
         meta_reg <= d;
         q_reg    <= meta_reg;
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/r2r_sar_adc.sv
// Successive-approximation ADC controller driving the R2R ladder and sampling an external comparator.
// Define SAR_CONTINUOUS_EN for free-running back-to-back conversions (start ignored).
module r2r_sar_adc
   import r2r_pkg::*;
#(
   parameter int DATA_WIDTH    = R2R_DATA_WIDTH,
   parameter int SETTLE_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  comp_in,
   output logic [DATA_WIDTH-1:0] dac_code,
   output logic                  busy,
   output logic [DATA_WIDTH-1:0] result,
   output logic                  valid
);

   localparam int IDX_W = $clog2(DATA_WIDTH);
   localparam int CNT_W = $clog2(SETTLE_CYCLES);

   localparam logic [DATA_WIDTH-1:0] MSB_CODE = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [IDX_W-1:0]      TOP_IDX  = IDX_W'(DATA_WIDTH - 1);
   localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   sar_state_t            state_reg,  state_next;
   logic [DATA_WIDTH-1:0] dac_reg,    dac_next;
   logic [DATA_WIDTH-1:0] result_reg, result_next;
   logic [IDX_W-1:0]      idx_reg,    idx_next;
   logic [CNT_W-1:0]      cnt_reg,    cnt_next;
   logic                  comp_s;
   logic                  launch;

   sync_2ff #(.WIDTH(1)) u_comp_sync (
      .clk (clk),
      .rst (rst),
      .d   (comp_in),
      .q   (comp_s)
   );

`ifdef SAR_CONTINUOUS_EN
   assign launch = 1'b1;
`else
   assign launch = start;
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg  <= IDLE;
         dac_reg    <= '0;
         result_reg <= '0;
         idx_reg    <= '0;
         cnt_reg    <= '0;
      end else begin
         state_reg  <= state_next;
         dac_reg    <= dac_next;
         result_reg <= result_next;
         idx_reg    <= idx_next;
         cnt_reg    <= cnt_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      dac_next    = dac_reg;
      result_next = result_reg;
      idx_next    = idx_reg;
      cnt_next    = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (launch) begin
               dac_next   = MSB_CODE;
               idx_next   = TOP_IDX;
               cnt_next   = CNT_LOAD;
               state_next = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_reg == '0) begin
               state_next = SAMPLE;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         SAMPLE: begin
            dac_next[idx_reg] = (comp_s == COMP_KEEP);
            if (idx_reg == '0) begin
               // Result is loaded on the edge into DONE so it changes together with valid.
               result_next = dac_next;
               state_next  = DONE;
            end else begin
               dac_next[idx_reg - IDX_W'(1)] = 1'b1;
               idx_next   = idx_reg - IDX_W'(1);
               cnt_next   = CNT_LOAD;
               state_next = SETTLE;
            end
         end
         DONE: begin
`ifdef SAR_CONTINUOUS_EN
            dac_next   = MSB_CODE;
            idx_next   = TOP_IDX;
            cnt_next   = CNT_LOAD;
            state_next = SETTLE;
`else
            state_next = IDLE;
`endif
         end
         default: state_next = IDLE;
      endcase
   end

   assign dac_code = dac_reg;
   assign result   = result_reg;
   assign busy     = (state_reg != IDLE);
   assign valid    = (state_reg == DONE);

endmodule

// File: doc/r2r_sar_adc.md
Name: r2r_sar_adc

Overview:
Successive-approximation ADC controller built on the board's R2R DAC and an external analog comparator.
- Drives a trial code onto the R2R ladder and waits for the ladder to settle.
- Samples the comparator and resolves one bit per step, MSB first.
- Presents the final code with a one-cycle valid strobe.
- This is the input-side counterpart of the sine/counter DAC output path: analog in, digital out.

Parameters:
DATA_WIDTH, 8, resolution in bits; equals the R2R ladder width.
SETTLE_CYCLES, 16, clocks the DAC is held per trial bit before sampling; must be >= 3 to cover the comparator synchroniser.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
start  in  1  request a conversion; sampled only in IDLE
comp_in  in  1  asynchronous comparator output; 1 = analog input >= DAC output
dac_code  out  DATA_WIDTH  code driven to the R2R ladder
busy  out  1  high in SETTLE, SAMPLE and DONE
result  out  DATA_WIDTH  last completed conversion
valid  out  1  one-cycle strobe, coincident with result update

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE.
  - dac_code, result, bit index, settle counter, synchroniser flops = 0.
  - busy=0, valid=0.
  - Reset is honoured in any state. A conversion in progress is abandoned with no valid strobe.
- comp_in passes through a 2-flop synchroniser (comp_s). Only comp_s is used.
- FSM: IDLE -> SETTLE -> SAMPLE -> (SETTLE | DONE) -> IDLE.
- IDLE:
  - dac_code holds its previous value (last result; 0 after reset).
  - start=1: dac_code <= 1<<(DATA_WIDTH-1), bit_idx <= DATA_WIDTH-1, settle_cnt <= SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - settle_cnt decrements each cycle.
  - When settle_cnt==0, go to SAMPLE. The state therefore lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (one cycle):
  - dac_code[bit_idx] <= comp_s: keep the bit if 1, clear it if 0.
  - If bit_idx==0, go to DONE.
  - Otherwise set dac_code[bit_idx-1]=1 in the same update, decrement bit_idx, reload settle_cnt, and go to SETTLE.
- DONE (one cycle): result <= dac_code, valid=1, go to IDLE.
- Latency: the start edge is in IDLE at cycle 0. valid is high in cycle DATA_WIDTH*(SETTLE_CYCLES+1)+1. Defaults: cycle 137.
- start while busy is ignored, including during DONE. It is not queued.
- start held high continuously gives back-to-back conversions with one IDLE cycle between them.
- result is stable between valid strobes.
- Outcome with an ideal comparator: result = floor(Vin/LSB), saturating at 0 and 2^DATA_WIDTH-1.
- Widths: bit_idx is clog2(DATA_WIDTH) bits. settle_cnt is clog2(SETTLE_CYCLES) bits. No arithmetic overflow is possible.

Optional Feature:
Macro SAR_CONTINUOUS_EN.
- Defined:
  - start is ignored.
  - After reset release the block enters a conversion automatically.
  - DONE transitions directly to SETTLE with MSB trial loading, skipping IDLE.
  - Conversion period is DATA_WIDTH*(SETTLE_CYCLES+1)+1 cycles. valid pulses once per period.
  - busy stays 1 after reset release.
- Undefined: start-triggered behaviour as specified above.

Decomposition:
- Package r2r_pkg:
  - sar_state_t enum (IDLE, SETTLE, SAMPLE, DONE).
  - Constant COMP_KEEP=1'b1 (comparator polarity).
  - Shared DATA_WIDTH default, so the counter/DAC path and this block agree on ladder width.
- Sub-module sync_2ff: generic 2-flop synchroniser, reset to 0 by rst. Instantiated for comp_in.

Test Plan:
Bench comparator model: comp_in = (vin_code >= dac_code), updated combinationally from dac_code.
- vin_code=0xA5, start pulsed once: dac_code sequence is 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5. result=0xA5 with valid high for exactly 1 cycle, at cycle 137.
- vin_code=0x00 gives result 0x00. vin_code=0xFF gives result 0xFF. Same latency in both cases.
- start re-pulsed at cycles 5 and 136 of a conversion: ignored, exactly one valid per original start, result unchanged from a single conversion.
- rst=0 at cycle 60 mid-conversion: next cycle busy=0, dac_code=0, result=0, no valid. A new start converts correctly.
- SETTLE_CYCLES=3, DATA_WIDTH=4, vin_code=0x9: result 0x9 at cycle 17.
- SAR_CONTINUOUS_EN defined, vin_code=0x3C, no start: valid every 137 cycles with result=0x3C. Change vin to 0x10 between conversions: next result 0x10.
